// File: rtl/trail_stamper_if.sv
// Frame-buffer and trail-ROM port bundle of the trail stamper.
// The master side issues addresses and strobes; read data returns one cycle later.
interface trail_stamper_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int TILE_W      = 2,
  parameter int TILE_H      = 4,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
);
  localparam int SEL_W = 3 + $clog2(NUM_PLAYERS);
  localparam int RA_W  = (TILE_W * TILE_H > 1) ? $clog2(TILE_W * TILE_H) : 1;

  logic [SEL_W-1:0]  rom_sel;
  logic [RA_W-1:0]   rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_re;
  logic [DATA_W-1:0] fb_rdata;
  logic              fb_we;
  logic [DATA_W-1:0] fb_wdata;

  modport master (
    output rom_sel, rom_addr, fb_addr, fb_re, fb_we, fb_wdata,
    input  rom_data, fb_rdata
  );

  modport slave (
    input  rom_sel, rom_addr, fb_addr, fb_re, fb_we, fb_wdata,
    output rom_data, fb_rdata
  );
endinterface

// File: rtl/trail_stamper.sv
// Detects bike moves, arbitrates round-robin, collision-checks and stamps a trail sprite.
// Stamp takes 2+2*TILE_W*TILE_H cycles after grant; no backpressure, a newer move overwrites a queued one.
module trail_stamper #(
  parameter int NUM_PLAYERS = 2,
  parameter int TILE_W      = 2,
  parameter int TILE_H      = 4,
  parameter int FB_STRIDE   = 320,
  parameter int ORIGIN_X    = 7,
  parameter int ORIGIN_Y    = 14,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       enable,
  input  logic [8*NUM_PLAYERS-1:0]   pos_x,
  input  logic [8*NUM_PLAYERS-1:0]   pos_y,
  input  logic [2*NUM_PLAYERS-1:0]   dir,
  trail_stamper_if.master            mem,
  output logic [NUM_PLAYERS-1:0]     collision,
  output logic [NUM_PLAYERS-1:0]     overrun,
  output logic                       busy
);
  localparam int SEL_W = 3 + $clog2(NUM_PLAYERS);
  localparam int GW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int RW    = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int CW    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int RA_W  = (TILE_W * TILE_H > 1) ? $clog2(TILE_W * TILE_H) : 1;

  localparam logic [ADDR_W-1:0] TH_A = ADDR_W'(TILE_H);
  localparam logic [ADDR_W-1:0] TW_A = ADDR_W'(TILE_W);
  localparam logic [ADDR_W-1:0] FS_A = ADDR_W'(FB_STRIDE);
  localparam logic [ADDR_W-1:0] OX_A = ADDR_W'(ORIGIN_X);
  localparam logic [ADDR_W-1:0] OY_A = ADDR_W'(ORIGIN_Y);
  localparam logic [RA_W-1:0]   TW_R = RA_W'(TILE_W);
  localparam logic [CW-1:0]     COL_LAST = CW'(TILE_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(TILE_H - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK_RD  = 3'd1;
  localparam logic [2:0] S_CHECK_CMP = 3'd2;
  localparam logic [2:0] S_ROM_RD    = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [7:0]             old_x_q [NUM_PLAYERS], old_x_d [NUM_PLAYERS];
  logic [7:0]             old_y_q [NUM_PLAYERS], old_y_d [NUM_PLAYERS];
  logic [1:0]             old_dir_q [NUM_PLAYERS], old_dir_d [NUM_PLAYERS];
  logic [7:0]             snap_x_q [NUM_PLAYERS], snap_x_d [NUM_PLAYERS];
  logic [7:0]             snap_y_q [NUM_PLAYERS], snap_y_d [NUM_PLAYERS];
  logic [1:0]             snap_t_q [NUM_PLAYERS], snap_t_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] pending_q, pending_d;
  logic [NUM_PLAYERS-1:0] collision_q, collision_d;
  logic [NUM_PLAYERS-1:0] overrun_q, overrun_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [1:0]             type_q, type_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;

  logic                   gnt_found;
  logic [GW-1:0]          gnt_idx;
  logic                   take;
  logic [1:0]             cur_dir;
  logic                   mv;
  logic [ADDR_W-1:0]      word_addr;
  logic [RA_W-1:0]        sprite_idx;

  // Farthest candidate first so the nearest pending player after last_grant wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j == (int'(last_grant_q) + 1 + i) % NUM_PLAYERS && pending_q[j]) begin
          gnt_found = 1'b1;
          gnt_idx   = GW'(j);
        end
      end
    end
  end

  assign take = (state_q == S_IDLE) && gnt_found;

  always_comb begin
    state_d      = state_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    old_dir_d    = old_dir_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    snap_t_d     = snap_t_q;
    pending_d    = pending_q;
    collision_d  = collision_q;
    overrun_d    = overrun_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    type_d       = type_q;
    base_d       = base_q;
    row_d        = row_q;
    col_d        = col_q;
    cur_dir      = '0;
    mv           = 1'b0;

    if (take) begin
      pending_d[gnt_idx] = 1'b0;
      grant_d            = gnt_idx;
      last_grant_d       = gnt_idx;
      type_d             = snap_t_q[gnt_idx];
      base_d             = (ADDR_W'(snap_y_q[gnt_idx]) * TH_A + OY_A) * FS_A
                           + ADDR_W'(snap_x_q[gnt_idx]) * TW_A + OX_A;
    end

    // A move after the grant-clear re-arms the request; it is only an overrun if that request was never granted.
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cur_dir = dir[2*p +: 2];
      mv      = (pos_x[8*p +: 8] != old_x_q[p]) || (pos_y[8*p +: 8] != old_y_q[p]);
      if (mv) begin
        old_x_d[p]   = pos_x[8*p +: 8];
        old_y_d[p]   = pos_y[8*p +: 8];
        old_dir_d[p] = cur_dir;
        snap_x_d[p]  = pos_x[8*p +: 8];
        snap_y_d[p]  = pos_y[8*p +: 8];
        snap_t_d[p]  = (cur_dir != old_dir_q[p]) ? 2'd3 : (cur_dir[1] ? 2'd1 : 2'd2);
        pending_d[p] = 1'b1;
        if (pending_q[p] && !(take && int'(gnt_idx) == p)) overrun_d[p] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE:      if (take) state_d = S_CHECK_RD;
      S_CHECK_RD:  state_d = S_CHECK_CMP;
      S_CHECK_CMP: begin
        if (mem.fb_rdata != '0) collision_d[grant_q] = 1'b1;
        row_d   = '0;
        col_d   = '0;
        state_d = S_ROM_RD;
      end
      S_ROM_RD:    state_d = S_WRITE;
      S_WRITE: begin
        if (col_q != COL_LAST) begin
          col_d   = col_q + 1'b1;
          state_d = S_ROM_RD;
        end else if (row_q != ROW_LAST) begin
          col_d   = '0;
          row_d   = row_q + 1'b1;
          state_d = S_ROM_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || !enable) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      collision_q  <= '0;
      overrun_q    <= '0;
      last_grant_q <= GW'(NUM_PLAYERS - 1);
      grant_q      <= '0;
      type_q       <= '0;
      base_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        old_x_q[p]   <= pos_x[8*p +: 8];
        old_y_q[p]   <= pos_y[8*p +: 8];
        old_dir_q[p] <= dir[2*p +: 2];
        snap_x_q[p]  <= '0;
        snap_y_q[p]  <= '0;
        snap_t_q[p]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      collision_q  <= collision_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      type_q       <= type_d;
      base_q       <= base_d;
      row_q        <= row_d;
      col_q        <= col_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      old_dir_q    <= old_dir_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      snap_t_q     <= snap_t_d;
    end
  end

  assign word_addr  = base_q + ADDR_W'(row_q) * FS_A + ADDR_W'(col_q);
  assign sprite_idx = RA_W'(row_q) * TW_R + RA_W'(col_q);

  always_comb begin
    mem.fb_re    = 1'b0;
    mem.fb_we    = 1'b0;
    mem.fb_addr  = '0;
    mem.fb_wdata = '0;
    mem.rom_sel  = '0;
    mem.rom_addr = '0;
    case (state_q)
      S_CHECK_RD: begin
        mem.fb_re   = 1'b1;
        mem.fb_addr = base_q;
      end
      S_ROM_RD: begin
        mem.rom_sel  = SEL_W'({grant_q, type_q});
        mem.rom_addr = sprite_idx;
      end
      S_WRITE: begin
        mem.fb_we    = 1'b1;
        mem.fb_addr  = word_addr;
        mem.fb_wdata = mem.rom_data;
      end
      default: ;
    endcase
  end

  assign collision = collision_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_trail_stamper.sv
// Scoreboard bench for trail_stamper at default parameters with a behavioural ROM and frame buffer.
module tb_trail_stamper;
  logic        Clk;
  logic        Reset;
  logic        enable;
  logic [15:0] pos_x;
  logic [15:0] pos_y;
  logic [3:0]  dir;
  logic [1:0]  collision;
  logic [1:0]  overrun;
  logic        busy;
  logic [15:0] coll_val;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int exp_rd_q[$];
  int exp_wr_q[$];
  int exp_wd_q[$];

  trail_stamper_if #(.NUM_PLAYERS(2), .TILE_W(2), .TILE_H(4), .ADDR_W(20), .DATA_W(16)) mem_if ();

  trail_stamper dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .enable    (enable),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .dir       (dir),
    .mem       (mem_if),
    .collision (collision),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite word encodes {sel, index} so each write identifies its ROM source.
  always @(posedge Clk) begin
    mem_if.rom_data <= 16'hA000 | {9'd0, mem_if.rom_sel, mem_if.rom_addr};
    mem_if.fb_rdata <= mem_if.fb_re ? coll_val : 16'h0000;
  end

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (mem_if.fb_re || mem_if.fb_we)
      check("re_we_exclusive", {31'd0, mem_if.fb_re & mem_if.fb_we}, 0);
    if (mem_if.fb_re) begin
      if (exp_rd_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_read: addr %0d, none expected", mem_if.fb_addr);
      end else begin
        check("rd_addr", {12'd0, mem_if.fb_addr}, exp_rd_q.pop_front());
      end
    end
    if (mem_if.fb_we) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", mem_if.fb_addr, mem_if.fb_wdata);
      end else begin
        check("wr_addr", {12'd0, mem_if.fb_addr}, exp_wr_q.pop_front());
        check("wr_data", {16'd0, mem_if.fb_wdata}, exp_wd_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_pos(input int p, input int x, input int y, input int d);
    pos_x[8*p +: 8] = 8'(x);
    pos_y[8*p +: 8] = 8'(y);
    dir[2*p +: 2]   = 2'(d);
  endtask

  task automatic push_stamp(input int base, input int sel, input int nwr);
    exp_rd_q.push_back(base);
    for (int i = 0; i < nwr; i++) begin
      exp_wr_q.push_back(base + (i / 2) * 320 + (i % 2));
      exp_wd_q.push_back(32'hA000 | (sel << 3) | i);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || busy) && k < 400) begin
      @(posedge Clk); #1;
      k++;
    end
    check(nm, (k < 400) ? 1 : 0, 1);
  endtask

  initial begin
    int lat;
    int dur;
    int start;
    int k;
    Reset = 1'b1; enable = 1'b0;
    pos_x = '0; pos_y = '0; dir = {2'd3, 2'd3};
    coll_val = 16'h0000;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_collision", collision, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fb_we", mem_if.fb_we, 0);
    check("rst_fb_re", mem_if.fb_re, 0);
    check("rst_fb_addr", mem_if.fb_addr, 0);
    Reset = 1'b0; enable = 1'b1;
    tick(5);
    check("no_move_on_enable", busy, 0);

    // Player 0 (0,0)->(1,0), horizontal: base 14*320+1*2+7 = 4489.
    set_pos(0, 1, 0, 3);
    push_stamp(4489, 1, 8);
    lat = 0;
    while (lat < 10) begin
      @(negedge Clk);
      if (busy) break;
      lat++;
    end
    check("start_latency", lat, 2);
    dur = 0;
    while (busy && dur < 100) begin
      dur++;
      @(negedge Clk);
    end
    check("busy_cycles", dur, 18);
    drain("drain_single");

    // Player 1 turns 3->0 while moving: corner, base (1*4+14)*320+7 = 5767.
    tick(1);
    set_pos(1, 0, 1, 0);
    push_stamp(5767, 7, 8);
    drain("drain_corner");
    // Same direction again: vertical, base (2*4+14)*320+7 = 7047.
    set_pos(1, 0, 2, 0);
    push_stamp(7047, 6, 8);
    drain("drain_vert");

    // Both players move together: p0 base 4491 first, then p1 base (3*4+14)*320+7 = 8327.
    set_pos(0, 2, 0, 3);
    set_pos(1, 0, 3, 0);
    push_stamp(4491, 1, 8);
    push_stamp(8327, 6, 8);
    drain("drain_simul");
    check("simul_overrun", overrun, 0);
    check("simul_collision", collision, 0);

    // Occupied tile origin: flag set, all writes still issued (base 4493).
    coll_val = 16'h0F00;
    set_pos(0, 3, 0, 3);
    push_stamp(4493, 1, 8);
    drain("drain_collision");
    check("collision_set", collision, 1);
    coll_val = 16'h0000;

    // p0 moves twice while p1 (base 9607) is stamping: only (5,0) -> 4497 is stamped.
    set_pos(1, 0, 4, 0);
    push_stamp(9607, 6, 8);
    tick(3);
    set_pos(0, 4, 0, 3);
    tick(1);
    set_pos(0, 5, 0, 3);
    push_stamp(4497, 1, 8);
    tick(1);
    drain("drain_overrun");
    check("overrun_set", overrun, 1);
    check("collision_held", collision, 1);

    enable = 1'b0;
    tick(2);
    check("en_low_collision", collision, 0);
    check("en_low_overrun", overrun, 0);
    check("en_low_busy", busy, 0);
    enable = 1'b1;
    tick(3);

    // Abort with Reset during the third write of base 4499.
    start = wr_cnt;
    set_pos(0, 6, 0, 3);
    push_stamp(4499, 1, 3);
    k = 0;
    while (wr_cnt < start + 3 && k < 100) begin
      @(negedge Clk); #1;
      k++;
    end
    check("abort_reach_third", (k < 100) ? 1 : 0, 1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_fb_we", mem_if.fb_we, 0);
    check("abort_busy", busy, 0);
    check("abort_flags", {collision, overrun}, 0);
    tick(3);
    Reset = 1'b0;
    tick(30);
    check("abort_writes", wr_cnt - start, 3);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    check("wr_queue_empty", exp_wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
